writeback_commit_unit_l1: RTL and testbench
===========================================

Name: writeback_commit_unit_l1

Overview:
- Basic (level-1) writeback/commit stage of the out-of-order-capable pipeline.
- Accepts finished instructions from one or more execute pipes over val/rdy channels and registers one per cycle.
- In the following cycle, broadcasts a completion notification (to the scoreboard/bypass logic) and a commit notification (to the architectural state/tracing).
- At this level, completion and commit coincide: no reorder buffer and no squash support.

Parameters:
- p_num_pipes, 1: number of execute-pipe input channels (≥1).
- p_seq_num_bits, 5: width of instruction sequence number.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- Ex_val  in  p_num_pipes  per-pipe valid.
- Ex_rdy  out  p_num_pipes  per-pipe ready.
- Ex_pc  in  32*p_num_pipes  per-pipe instruction PC (pipe i at bits [32i+31:32i]).
- Ex_seq_num  in  p_seq_num_bits*p_num_pipes  per-pipe sequence number.
- Ex_waddr  in  5*p_num_pipes  per-pipe destination register.
- Ex_wdata  in  32*p_num_pipes  per-pipe writeback data.
- Ex_wen  in  p_num_pipes  per-pipe write enable.
- complete_val  out  1  completion notification valid.
- complete_seq_num  out  p_seq_num_bits  completed sequence number.
- complete_waddr  out  5  completed destination register.
- complete_wdata  out  32  completed data.
- complete_wen  out  1  completed write enable.
- commit_val  out  1  commit notification valid.
- commit_pc  out  32  committed PC.
- commit_seq_num  out  p_seq_num_bits  committed sequence number.
- commit_waddr  out  5  committed destination register.
- commit_wdata  out  32  committed data.
- commit_wen  out  1  committed write enable.

Behaviour:
- Single pipeline register, W_reg: fields val, pc, seq_num, waddr, wdata, wen.
- Reset: W_reg.val=0, so complete_val=0 and commit_val=0 in the cycle after rst is sampled high. Data fields are don't-care; implementation clears them to 0.
- Arbitration: fixed priority, lowest pipe index wins.
  - Ex_rdy[i]=1 only for the granted pipe; granted = lowest i with Ex_val[i]=1.
  - Ex_rdy is computed combinationally from Ex_val.
  - When no pipe is valid, Ex_rdy[0]=1 and all others are 0.
  - At most one transfer per cycle.
  - The stage never stalls: notifications have no backpressure.
- Transfer: occurs when Ex_val[i] && Ex_rdy[i] at a rising edge. W_reg then loads pipe i's fields and W_reg.val is set to 1. If no transfer occurs, W_reg.val is set to 0.
- Outputs are combinational from W_reg, giving one-cycle latency from accept to notification.
  - complete_* = W_reg.{seq_num,waddr,wdata,wen}; complete_val = W_reg.val.
  - commit_* = W_reg.{pc,seq_num,waddr,wdata,wen}; commit_val = W_reg.val.
  - Complete and commit for the same instruction assert in the same cycle.
- wen=0 instructions (stores, branches) still produce both notifications, with wen=0 and waddr/wdata passed through unchanged.
- waddr=0 is passed through unchanged; the consumer ignores writes to x0.
- Sequence numbers are passed through unmodified. No ordering check is made and wrap-around is irrelevant.
- Back-to-back: a new message may be accepted every cycle, giving a notification every cycle.
- Reset mid-operation: a message in W_reg is dropped, with no notification. An input presented during the rst cycle is not accepted (Ex_rdy=0 while rst=1).
- Provide a linetrace function: input summary | "seq:waddr:wdata" of W_reg, or blanks when invalid.

Test Plan:
- Single message, 1 pipe: send pc=0x200, seq=1, waddr=5, wdata=0xDEADBEEF, wen=1 -> next cycle complete(1,5,0xDEADBEEF,1) and commit(0x200,1,5,0xDEADBEEF,1), both with val=1 for exactly one cycle.
- wen=0: send pc=0x204, seq=2, waddr=0, wdata=0, wen=0 -> complete(2,0,0,0) and commit(0x204,2,0,0,0).
- Back-to-back stream of seq 0..7 (wraps with 3-bit seq), wdata=seq*4 -> one complete+commit per cycle in order; seq wraps 7->0 correctly.
- Random input delays (send interval 1–3 cycles) -> notifications appear exactly one cycle after each accept; val=0 in idle cycles.
- Two pipes both valid: pipe0 seq=3, pipe1 seq=4 -> cycle n: Ex_rdy=01, seq 3 notified at n+1; pipe1 accepted at n+1, seq 4 notified at n+2.
- Reset during traffic: assert rst while W_reg is valid -> complete_val=commit_val=0 the next cycle; traffic resumes normally after rst deasserts.

Source files
------------

// File: rtl/writeback_commit_unit_l1_if.sv
// Writeback/commit channel bundle: execute-pipe val/rdy inputs
// plus completion and commit notification outputs.
interface writeback_commit_unit_l1_if #(
   parameter int p_num_pipes    = 1,
   parameter int p_seq_num_bits = 5
);
   logic [p_num_pipes-1:0]                Ex_val;
   logic [p_num_pipes-1:0]                Ex_rdy;
   logic [32*p_num_pipes-1:0]             Ex_pc;
   logic [p_seq_num_bits*p_num_pipes-1:0] Ex_seq_num;
   logic [5*p_num_pipes-1:0]              Ex_waddr;
   logic [32*p_num_pipes-1:0]             Ex_wdata;
   logic [p_num_pipes-1:0]                Ex_wen;

   logic                      complete_val;
   logic [p_seq_num_bits-1:0] complete_seq_num;
   logic [4:0]                complete_waddr;
   logic [31:0]               complete_wdata;
   logic                      complete_wen;

   logic                      commit_val;
   logic [31:0]               commit_pc;
   logic [p_seq_num_bits-1:0] commit_seq_num;
   logic [4:0]                commit_waddr;
   logic [31:0]               commit_wdata;
   logic                      commit_wen;

   modport master (
      output Ex_val, Ex_pc, Ex_seq_num, Ex_waddr, Ex_wdata, Ex_wen,
      input  Ex_rdy,
      input  complete_val, complete_seq_num, complete_waddr,
      input  complete_wdata, complete_wen,
      input  commit_val, commit_pc, commit_seq_num, commit_waddr,
      input  commit_wdata, commit_wen
   );

   modport slave (
      input  Ex_val, Ex_pc, Ex_seq_num, Ex_waddr, Ex_wdata, Ex_wen,
      output Ex_rdy,
      output complete_val, complete_seq_num, complete_waddr,
      output complete_wdata, complete_wen,
      output commit_val, commit_pc, commit_seq_num, commit_waddr,
      output commit_wdata, commit_wen
   );
endinterface

// File: rtl/writeback_commit_unit_l1.sv
// Level-1 writeback/commit stage: fixed-priority accept from execute
// pipes into W_reg, then complete+commit notify one cycle later.
// Ports: clk, rst (sync, active-high), wb (slave: Ex_* in, notify out).
module writeback_commit_unit_l1 #(
   parameter int p_num_pipes    = 1,
   parameter int p_seq_num_bits = 5
) (
   input logic clk,
   input logic rst,
   writeback_commit_unit_l1_if.slave wb
);

   typedef struct packed {
      logic                      val;
      logic [31:0]               pc;
      logic [p_seq_num_bits-1:0] seq_num;
      logic [4:0]                waddr;
      logic [31:0]               wdata;
      logic                      wen;
   } w_reg_t;

   w_reg_t w_reg;
   w_reg_t sel;
   logic   found;
   logic   xfer;

   // Lowest valid pipe wins; with no requester, pipe 0 is shown ready.
   always_comb begin
      wb.Ex_rdy   = '0;
      found       = 1'b0;
      sel         = '0;
      sel.pc      = wb.Ex_pc[31:0];
      sel.seq_num = wb.Ex_seq_num[p_seq_num_bits-1:0];
      sel.waddr   = wb.Ex_waddr[4:0];
      sel.wdata   = wb.Ex_wdata[31:0];
      sel.wen     = wb.Ex_wen[0];
      for (int i = 0; i < p_num_pipes; i++) begin
         if (!found && wb.Ex_val[i]) begin
            found        = 1'b1;
            wb.Ex_rdy[i] = 1'b1;
            sel.pc       = wb.Ex_pc[32*i +: 32];
            sel.seq_num  = wb.Ex_seq_num[p_seq_num_bits*i +: p_seq_num_bits];
            sel.waddr    = wb.Ex_waddr[5*i +: 5];
            sel.wdata    = wb.Ex_wdata[32*i +: 32];
            sel.wen      = wb.Ex_wen[i];
         end
      end
      if (!found)
         wb.Ex_rdy[0] = 1'b1;
      if (rst)
         wb.Ex_rdy = '0;
      sel.val = 1'b1;
      xfer    = found && !rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_reg <= '0;
      end else begin
         w_reg.val <= xfer;
         if (xfer)
            w_reg <= sel;
      end
   end

   assign wb.complete_val     = w_reg.val;
   assign wb.complete_seq_num = w_reg.seq_num;
   assign wb.complete_waddr   = w_reg.waddr;
   assign wb.complete_wdata   = w_reg.wdata;
   assign wb.complete_wen     = w_reg.wen;

   assign wb.commit_val     = w_reg.val;
   assign wb.commit_pc      = w_reg.pc;
   assign wb.commit_seq_num = w_reg.seq_num;
   assign wb.commit_waddr   = w_reg.waddr;
   assign wb.commit_wdata   = w_reg.wdata;
   assign wb.commit_wen     = w_reg.wen;

   function automatic string line_trace();
      string w;
      if (w_reg.val)
         w = $sformatf("%2h:%2d:%8h", w_reg.seq_num, w_reg.waddr,
                       w_reg.wdata);
      else
         w = "                ";
      return $sformatf("%b/%b | %s", wb.Ex_val, wb.Ex_rdy, w);
   endfunction

endmodule

// File: tb/tb_writeback_commit_unit_l1.sv
// Directed bench for writeback_commit_unit_l1 with two pipes and
// 3-bit sequence numbers.
module tb_writeback_commit_unit_l1;

   localparam int NP = 2;
   localparam int SB = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   writeback_commit_unit_l1_if #(.p_num_pipes(NP), .p_seq_num_bits(SB)) wb ();

   writeback_commit_unit_l1 #(.p_num_pipes(NP), .p_seq_num_bits(SB)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
   endtask

   task automatic drive(input int p, input logic v, input logic [31:0] pc,
                        input logic [SB-1:0] seq, input logic [4:0] wa,
                        input logic [31:0] wd, input logic we);
      wb.Ex_val[p]              = v;
      wb.Ex_pc[32*p +: 32]      = pc;
      wb.Ex_seq_num[SB*p +: SB] = seq;
      wb.Ex_waddr[5*p +: 5]     = wa;
      wb.Ex_wdata[32*p +: 32]   = wd;
      wb.Ex_wen[p]              = we;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_msg(input string tag, input logic [31:0] pc,
                            input logic [SB-1:0] seq, input logic [4:0] wa,
                            input logic [31:0] wd, input logic we);
      check({tag, ".cpl_val"}, 64'(wb.complete_val), 64'd1);
      check({tag, ".cmt_val"}, 64'(wb.commit_val), 64'd1);
      check({tag, ".cpl_seq"}, 64'(wb.complete_seq_num), 64'(seq));
      check({tag, ".cpl_wa"}, 64'(wb.complete_waddr), 64'(wa));
      check({tag, ".cpl_wd"}, 64'(wb.complete_wdata), 64'(wd));
      check({tag, ".cpl_we"}, 64'(wb.complete_wen), 64'(we));
      check({tag, ".cmt_pc"}, 64'(wb.commit_pc), 64'(pc));
      check({tag, ".cmt_seq"}, 64'(wb.commit_seq_num), 64'(seq));
      check({tag, ".cmt_wa"}, 64'(wb.commit_waddr), 64'(wa));
      check({tag, ".cmt_wd"}, 64'(wb.commit_wdata), 64'(wd));
      check({tag, ".cmt_we"}, 64'(wb.commit_wen), 64'(we));
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".cpl_val"}, 64'(wb.complete_val), 64'd0);
      check({tag, ".cmt_val"}, 64'(wb.commit_val), 64'd0);
   endtask

   int gaps [5] = '{1, 3, 2, 1, 3};

   initial begin
      wb.Ex_val     = '0;
      wb.Ex_pc      = '0;
      wb.Ex_seq_num = '0;
      wb.Ex_waddr   = '0;
      wb.Ex_wdata   = '0;
      wb.Ex_wen     = '0;

      // reset, with an input offered that must not be accepted
      drive(0, 1'b1, 32'h100, 3'd6, 5'd1, 32'h11, 1'b1);
      #1;
      check("rst.rdy", 64'(wb.Ex_rdy), 64'b00);
      step();
      step();
      check_idle("rst");
      drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      rst = 1'b0;
      #1;
      check("idle.rdy", 64'(wb.Ex_rdy), 64'b01);
      step();
      check_idle("post_rst");

      // single message
      drive(0, 1'b1, 32'h200, 3'd1, 5'd5, 32'hDEADBEEF, 1'b1);
      #1;
      check("t1.rdy", 64'(wb.Ex_rdy), 64'b01);
      step();
      drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      check_msg("t1", 32'h200, 3'd1, 5'd5, 32'hDEADBEEF, 1'b1);
      step();
      check_idle("t1.after");

      // wen=0, waddr=0 pass through
      drive(0, 1'b1, 32'h204, 3'd2, 5'd0, 32'h0, 1'b0);
      step();
      drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      check_msg("t2", 32'h204, 3'd2, 5'd0, 32'h0, 1'b0);
      step();
      check_idle("t2.after");

      // back-to-back, seq wraps 7 -> 0
      for (int i = 0; i < 9; i++) begin
         drive(0, 1'b1, 32'h300 + 32'(4*i), 3'(i), 5'(i + 1), 32'(4*(i % 8)),
               1'b1);
         step();
         check_msg($sformatf("b2b%0d", i), 32'h300 + 32'(4*i), 3'(i),
                   5'(i + 1), 32'(4*(i % 8)), 1'b1);
      end
      drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      step();
      check_idle("b2b.after");

      // gapped traffic
      for (int i = 0; i < 5; i++) begin
         drive(0, 1'b1, 32'h400 + 32'(i), 3'(i + 3), 5'(i + 10),
               32'hA000 + 32'(i), 1'(i % 2));
         step();
         drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
         check_msg($sformatf("gap%0d", i), 32'h400 + 32'(i), 3'(i + 3),
                   5'(i + 10), 32'hA000 + 32'(i), 1'(i % 2));
         for (int g = 1; g < gaps[i]; g++) begin
            step();
            check_idle($sformatf("gap%0d.idle%0d", i, g));
         end
      end
      step();
      check_idle("gap.after");

      // two pipes: lowest index first
      drive(0, 1'b1, 32'h500, 3'd3, 5'd3, 32'h33, 1'b1);
      drive(1, 1'b1, 32'h600, 3'd4, 5'd4, 32'h44, 1'b1);
      #1;
      check("arb.rdy0", 64'(wb.Ex_rdy), 64'b01);
      step();
      drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      check_msg("arb.p0", 32'h500, 3'd3, 5'd3, 32'h33, 1'b1);
      #1;
      check("arb.rdy1", 64'(wb.Ex_rdy), 64'b10);
      step();
      drive(1, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      check_msg("arb.p1", 32'h600, 3'd4, 5'd4, 32'h44, 1'b1);
      step();
      check_idle("arb.after");

      // reset with W_reg valid
      drive(0, 1'b1, 32'h700, 3'd5, 5'd7, 32'h77, 1'b1);
      step();
      check_msg("rr.pre", 32'h700, 3'd5, 5'd7, 32'h77, 1'b1);
      drive(0, 1'b1, 32'h704, 3'd6, 5'd8, 32'h88, 1'b1);
      rst = 1'b1;
      #1;
      check("rr.rdy", 64'(wb.Ex_rdy), 64'b00);
      step();
      check_idle("rr.drop");
      rst = 1'b0;
      drive(0, 1'b1, 32'h708, 3'd7, 5'd9, 32'h99, 1'b1);
      step();
      drive(0, 1'b0, 32'h0, 3'd0, 5'd0, 32'h0, 1'b0);
      check_msg("rr.resume", 32'h708, 3'd7, 5'd9, 32'h99, 1'b1);
      step();
      check_idle("rr.after");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
